// File: rtl/csa_pkg.sv
// Shared constants and types for the pipelined carry-select adder/subtractor.
// Optional saturation support in the top is selected with the CSA_PIPE_SAT_EN macro.
package csa_pkg;

    // Default datapath geometry: 32-bit operands split into 8-bit segments.
    localparam int CSA_WIDTH = 32;
    localparam int CSA_SEG_W = 8;

    // Operation mode encoding on the sub input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Result flag bundle produced by the last stage.
    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } csa_flags_t;

endpackage

// File: rtl/csa_seg.sv
// Combinational SEG_W-bit dual-carry segment: both carry-in results are formed
// in parallel and the registered carry from the previous stage picks one.
// cmsb is the carry into the segment MSB, recovered as sum^a^b at that bit.
module csa_seg
    import csa_pkg::*;
#(
    parameter int SEG_W = CSA_SEG_W
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin_sel,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [SEG_W:0] sum0_s;
    logic [SEG_W:0] sum1_s;

    assign sum0_s = {1'b0, a} + {1'b0, b};
    assign sum1_s = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, 1'b1};

    // Select the precomputed sum matching the incoming carry and derive the MSB carry-in.
    always_comb begin
        if (cin_sel) begin
            {cout, sum} = sum1_s;
        end else begin
            {cout, sum} = sum0_s;
        end
        cmsb = sum[SEG_W-1] ^ a[SEG_W-1] ^ b[SEG_W-1];
    end

endmodule

// File: rtl/csa_pipe_addsub.sv
// Pipelined carry-select adder/subtractor. One SEG_W segment is resolved per
// stage; unprocessed operand segments ride along in skew registers and finished
// result segments in deskew registers so a whole beat emerges at once after
// NSEG cycles. A single global enable stalls every stage together.
// Optional build macro: CSA_PIPE_SAT_EN adds the sat input and signed clamping.
module csa_pipe_addsub
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int SEG_W = CSA_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef CSA_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // WIDTH must be a multiple of SEG_W and give at least two segments.
    localparam int NSEG = WIDTH / SEG_W;
    localparam int LAST = NSEG - 1;

    logic             en_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;

    // Per-stage state for stages 0..LAST-1; stage LAST is the output register.
    logic [NSEG-1:0]  valid_r;
    logic [WIDTH-1:0] a_r     [LAST];
    logic [WIDTH-1:0] b_r     [LAST];
    logic [WIDTH-1:0] res_r   [LAST];
    logic [LAST-1:0]  carry_r;
`ifdef CSA_PIPE_SAT_EN
    logic [LAST-1:0]  sat_r;
`endif

    logic [SEG_W-1:0] seg_a_s   [NSEG];
    logic [SEG_W-1:0] seg_b_s   [NSEG];
    logic [NSEG-1:0]  seg_cin_s;
    logic [SEG_W-1:0] seg_sum_s [NSEG];
    logic [NSEG-1:0]  seg_cout_s;
    logic [NSEG-1:0]  seg_cmsb_s;
    logic [WIDTH-1:0] res_nxt_s [NSEG];

    logic [WIDTH-1:0] res_final_s;
    csa_flags_t       flags_s;
    logic [WIDTH-1:0] sum_r;
    csa_flags_t       flags_r;

    // Only the top segment's MSB carry matters for overflow.
    logic unused_s;
    assign unused_s = ^seg_cmsb_s[LAST-1:0];

    assign en_s     = ~valid_r[LAST] | out_ready;
    assign in_ready = en_s;

    // Subtraction is A + ~B + ~borrow_in, so invert B and the incoming carry.
    assign b_eff_s = (sub == OP_ADD) ? b : ~b;
    assign c0_s    = (sub == OP_SUB) ? ~cin : cin;

    // Route each stage's operand segment and selecting carry into its segment adder.
    always_comb begin
        seg_a_s[0]   = a[SEG_W-1:0];
        seg_b_s[0]   = b_eff_s[SEG_W-1:0];
        seg_cin_s[0] = c0_s;
        for (int k = 1; k < NSEG; k++) begin
            seg_a_s[k]   = a_r[k-1][k*SEG_W +: SEG_W];
            seg_b_s[k]   = b_r[k-1][k*SEG_W +: SEG_W];
            seg_cin_s[k] = carry_r[k-1];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        csa_seg #(
            .SEG_W(SEG_W)
        ) u_seg (
            .a      (seg_a_s[k]),
            .b      (seg_b_s[k]),
            .cin_sel(seg_cin_s[k]),
            .sum    (seg_sum_s[k]),
            .cout   (seg_cout_s[k]),
            .cmsb   (seg_cmsb_s[k])
        );
    end

    // Merge each stage's new segment into the partial result carried from the stage before.
    always_comb begin
        res_nxt_s[0]              = '0;
        res_nxt_s[0][SEG_W-1:0]   = seg_sum_s[0];
        for (int k = 1; k < NSEG; k++) begin
            res_nxt_s[k]                  = res_r[k-1];
            res_nxt_s[k][k*SEG_W +: SEG_W] = seg_sum_s[k];
        end
    end

    // Last stage: flags from the top segment, optional clamp, zero on the final value.
    always_comb begin
        flags_s.cout = seg_cout_s[LAST];
        flags_s.ovf  = seg_cout_s[LAST] ^ seg_cmsb_s[LAST];
`ifdef CSA_PIPE_SAT_EN
        if (sat_r[LAST-1] && flags_s.ovf) begin
            if (res_nxt_s[LAST][WIDTH-1]) begin
                res_final_s = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                res_final_s = {1'b1, {(WIDTH-1){1'b0}}};
            end
        end else begin
            res_final_s = res_nxt_s[LAST];
        end
`else
        res_final_s = res_nxt_s[LAST];
`endif
        flags_s.zero = (res_final_s == {WIDTH{1'b0}});
    end

    // Advance valid bits, skewed operands, carries and partial results on the global enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            carry_r <= '0;
            for (int k = 0; k < LAST; k++) begin
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                res_r[k] <= '0;
            end
        end else if (en_s) begin
            valid_r[0] <= in_valid;
            a_r[0]     <= a;
            b_r[0]     <= b_eff_s;
            res_r[0]   <= res_nxt_s[0];
            carry_r[0] <= seg_cout_s[0];
            for (int k = 1; k < LAST; k++) begin
                valid_r[k] <= valid_r[k-1];
                a_r[k]     <= a_r[k-1];
                b_r[k]     <= b_r[k-1];
                res_r[k]   <= res_nxt_s[k];
                carry_r[k] <= seg_cout_s[k];
            end
            valid_r[LAST] <= valid_r[LAST-1];
        end
    end

`ifdef CSA_PIPE_SAT_EN
    // Carry the per-beat saturation request alongside its operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_r <= '0;
        end else if (en_s) begin
            sat_r <= {sat_r[LAST-2:0], sat};
        end
    end
`endif

    // Output register: result and flags, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r   <= '0;
            flags_r <= '0;
        end else if (en_s) begin
            sum_r   <= res_final_s;
            flags_r <= flags_s;
        end
    end

    assign out_valid = valid_r[LAST];
    assign sum       = sum_r;
    assign cout      = flags_r.cout;
    assign ovf       = flags_r.ovf;
    assign zero      = flags_r.zero;

endmodule

// File: tb/tb_csa_pipe_addsub.sv
// Self-checking bench for csa_pipe_addsub at default geometry (32 bits, 4 stages).
// Directed vectors come from a table with hand-computed results; random traffic
// is scored against an arithmetic model of add/subtract with flags.
// Build with CSA_PIPE_SAT_EN defined to include the saturation vectors.
module tb_csa_pipe_addsub;

    localparam int W    = 32;
    localparam int NSEG = 4;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic        sat;
        logic [31:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
        logic        e_zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_drv;
    logic [31:0] b_drv;
    logic        cin_drv;
    logic        sub_drv;
    logic        sat_drv;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int   n_checks = 0;
    int   n_pass   = 0;
    res_t exp_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    csa_pipe_addsub #(
        .WIDTH(W),
        .SEG_W(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a_drv),
        .b        (b_drv),
        .cin      (cin_drv),
        .sub      (sub_drv),
`ifdef CSA_PIPE_SAT_EN
        .sat      (sat_drv),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operands.
    function automatic res_t model(input logic [31:0] fa, input logic [31:0] fb,
                                   input logic fcin, input logic fsub, input logic fsat);
        res_t   r;
        longint ua, ub, sa, sb, c, ur, sr;
        ua = longint'(fa);
        ub = longint'(fb);
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        c  = fcin ? 64'sd1 : 64'sd0;
        if (fsub) begin
            ur     = ua - ub - c;
            sr     = sa - sb - c;
            r.cout = (ur >= 64'sd0);
        end else begin
            ur     = ua + ub + c;
            sr     = sa + sb + c;
            r.cout = (ur > 64'sd4294967295);
        end
        r.sum = ur[31:0];
        r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (fsat && r.ovf) begin
            r.sum = (sr > 64'sd0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end
        r.zero = (r.sum == 32'h0);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        case ($urandom_range(0, 5))
            0:       a_drv = 32'h7FFF_FFFF;
            1:       a_drv = 32'h8000_0000;
            2:       a_drv = 32'hFFFF_FFFF;
            default: a_drv = $urandom();
        endcase
        b_drv   = ($urandom_range(0, 3) == 0) ? 32'(($urandom_range(0, 2))) : $urandom();
        cin_drv = 1'($urandom_range(0, 1));
        sub_drv = 1'($urandom_range(0, 1));
`ifdef CSA_PIPE_SAT_EN
        sat_drv = 1'($urandom_range(0, 1));
`else
        sat_drv = 1'b0;
`endif
    endtask

    // One isolated beat: exact NSEG-cycle latency plus table expectations.
    task automatic apply_vec(input vec_t v);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_drv     = v.a;
        b_drv     = v.b;
        cin_drv   = v.cin;
        sub_drv   = v.sub;
        sat_drv   = v.sat;
        step();
        in_valid = 1'b0;
        repeat (NSEG - 2) step();
        chk("lat_early_valid", out_valid, 1'b0);
        step();
        chk("lat_valid", out_valid, 1'b1);
        chk("vec_sum", sum, v.e_sum);
        chk("vec_cout", cout, v.e_cout);
        chk("vec_ovf", ovf, v.e_ovf);
        chk("vec_zero", zero, v.e_zero);
    endtask

    task automatic drain();
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard and protocol monitor, sampled on the falling edge.
    initial begin
        res_t e;
        res_t held;
        logic stall_prev;
        stall_prev = 1'b0;
        held       = '{32'h0, 1'b0, 1'b0, 1'b0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
                if (stall_prev) begin
                    chk("hold_valid", out_valid, 1'b1);
                    chk("hold_sum", sum, held.sum);
                    chk("hold_flags", {cout, ovf, zero}, {held.cout, held.ovf, held.zero});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out", out_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_sum", sum, e.sum);
                        chk("sb_cout", cout, e.cout);
                        chk("sb_ovf", ovf, e.ovf);
                        chk("sb_zero", zero, e.zero);
                    end
                end
                stall_prev = out_valid && !out_ready;
                held       = '{sum, cout, ovf, zero};
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(a_drv, b_drv, cin_drv, sub_drv, sat_drv));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   left;
        int   cyc;
        int   seen;
        logic acc;
        logic new_beat;

        // a, b, cin, sub, sat, expected sum, cout, ovf, zero
        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{32'h00FF_00FF, 32'h0000_FF01, 1'b0, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'h8000_000F, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1});
`ifdef CSA_PIPE_SAT_EN
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0010, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0});
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_drv     = 32'h0;
        b_drv     = 32'h0;
        cin_drv   = 1'b0;
        sub_drv   = 1'b0;
        sat_drv   = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 32'h0);
        chk("rst_flags", {cout, ovf, zero}, 3'b000);

        // Release and present the first beat in the same cycle.
        rst_n = 1'b1;
        foreach (vecs[i]) apply_vec(vecs[i]);
        drain();

        // Random stream with out_ready pattern 1,0,0,1 and occasional bubbles.
        left     = 40;
        cyc      = 0;
        new_beat = 1'b1;
        while (left > 0 && cyc < 1000) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (new_beat) begin
                rand_beat();
                in_valid = ($urandom_range(0, 4) != 0);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) left--;
            new_beat = acc || !in_valid;
            cyc++;
        end
        chk("bp_all_accepted", 32'(left), 32'd0);
        drain();

        // Back-to-back stream: one result per cycle once the pipe is full.
        for (int i = 0; i < 16 + NSEG; i++) begin
            if (i < 16) begin
                rand_beat();
                in_valid = 1'b1;
                chk("tput_in_ready", in_ready, 1'b1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= NSEG - 1 && i < NSEG - 1 + 16) begin
                chk("tput_out_valid", out_valid, 1'b1);
            end
        end
        drain();

        // Reset with beats in flight: outputs clear at once, nothing stale afterwards.
        for (int i = 0; i < 6; i++) begin
            rand_beat();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("prerst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_sum", sum, 32'h0);
        chk("midrst_flags", {cout, ovf, zero}, 3'b000);
        step();
        rst_n = 1'b1;
        seen  = 0;
        repeat (12) begin
            step();
            if (out_valid) seen++;
        end
        chk("no_stale_beats", 32'(seen), 32'd0);
        apply_vec(vecs[1]);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
